// File: rtl/channel_mux_arb_if.sv
// rtl/channel_mux_arb_if.sv - producer/consumer handshake bundle for channel_mux_arb
interface channel_mux_arb_if #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4
);
    localparam int SEL_W = $clog2(CHANNELS);

    logic                      cs;
    logic                      mode;
    logic [SEL_W-1:0]          sel;
    logic [CHANNELS*WIDTH-1:0] in_data;
    logic [CHANNELS-1:0]       in_valid;
    logic [CHANNELS-1:0]       in_ready;
    logic [WIDTH-1:0]          out_data;
    logic [SEL_W-1:0]          out_chan;
    logic                      out_valid;
    logic                      out_ready;

    modport master (
        output cs, mode, sel, in_data, in_valid, out_ready,
        input  in_ready, out_data, out_chan, out_valid
    );

    modport slave (
        input  cs, mode, sel, in_data, in_valid, out_ready,
        output in_ready, out_data, out_chan, out_valid
    );
endinterface

// File: rtl/channel_mux_arb.sv
// rtl/channel_mux_arb.sv - registered N-channel mux/arbiter, explicit select or round-robin
module channel_mux_arb #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    channel_mux_arb_if.slave    bus
);
    localparam int SEL_W = $clog2(CHANNELS);

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [SEL_W-1:0] chan_q, chan_d;
    logic [SEL_W-1:0] rr_ptr_q, rr_ptr_d;

    logic             can_load;
    logic             grant_valid;
    logic [SEL_W-1:0] grant_idx;
    logic [WIDTH-1:0] grant_data;
    logic [SEL_W:0]   rr_sum;
    logic [SEL_W-1:0] rr_idx;

    assign can_load = (state_q == ST_EMPTY) || bus.out_ready;

    // Grant is gated by rst_n so in_ready drops as soon as reset asserts.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        rr_sum      = '0;
        rr_idx      = '0;
        if (rst_n && bus.cs && can_load) begin
            if (!bus.mode) begin
                if (({1'b0, bus.sel} < (SEL_W+1)'(CHANNELS)) && bus.in_valid[bus.sel]) begin
                    grant_valid = 1'b1;
                    grant_idx   = bus.sel;
                end
            end else begin
                for (int i = 0; i < CHANNELS; i++) begin
                    rr_sum = {1'b0, rr_ptr_q} + (SEL_W+1)'(i);
                    if (rr_sum >= (SEL_W+1)'(CHANNELS)) begin
                        rr_sum = rr_sum - (SEL_W+1)'(CHANNELS);
                    end
                    rr_idx = rr_sum[SEL_W-1:0];
                    if (!grant_valid && bus.in_valid[rr_idx]) begin
                        grant_valid = 1'b1;
                        grant_idx   = rr_idx;
                    end
                end
            end
        end
    end

    always_comb begin
        grant_data = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (grant_idx == SEL_W'(i)) begin
                grant_data = bus.in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    assign bus.in_ready = grant_valid ? (CHANNELS'(1) << grant_idx) : '0;

    // A grant always implies a transfer: it requires in_valid of that channel.
    always_comb begin
        state_d  = state_q;
        data_d   = data_q;
        chan_d   = chan_q;
        rr_ptr_d = rr_ptr_q;
        case (state_q)
            ST_EMPTY: begin
                if (grant_valid) begin
                    state_d = ST_FULL;
                end
            end
            ST_FULL: begin
                if (bus.out_ready && !grant_valid) begin
                    state_d = ST_EMPTY;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
        if (grant_valid) begin
            data_d = grant_data;
            chan_d = grant_idx;
            if (bus.mode) begin
                rr_ptr_d = (grant_idx == SEL_W'(CHANNELS-1)) ? '0 : grant_idx + SEL_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_EMPTY;
            data_q   <= '0;
            chan_q   <= '0;
            rr_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            data_q   <= data_d;
            chan_q   <= chan_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    assign bus.out_valid = (state_q == ST_FULL);
    assign bus.out_data  = data_q;
    assign bus.out_chan  = chan_q;
endmodule

// File: tb/tb_channel_mux_arb.sv
// tb/tb_channel_mux_arb.sv - self-checking bench for channel_mux_arb
module tb_channel_mux_arb;
    localparam int N = 4;

    logic clk;
    logic rst_n;
    int   vectors;
    int   miscompares;

    channel_mux_arb_if #(.WIDTH(8), .CHANNELS(N)) bus();

    channel_mux_arb #(.WIDTH(8), .CHANNELS(N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: one-entry output slot plus a round-robin start index.
    logic       m_valid;
    logic [7:0] m_data;
    logic [1:0] m_chan;
    int         m_rr;

    typedef struct {
        logic        cs;
        logic        mode;
        logic [1:0]  sel;
        logic [31:0] data;
        logic [3:0]  valid;
        logic        ready;
        logic [3:0]  x_rdy;
        logic        x_ov;
        logic [7:0]  x_od;
        logic [1:0]  x_oc;
    } vec_t;

    vec_t tbl[10];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int model_grant(input logic c, input logic m, input logic [1:0] s,
                                       input logic [3:0] v, input logic r);
        if (!c || (m_valid && !r)) return -1;
        if (!m) return (int'(s) < N && v[s]) ? int'(s) : -1;
        for (int k = 0; k < N; k++) begin
            if (v[(m_rr + k) % N]) return (m_rr + k) % N;
        end
        return -1;
    endfunction

    function automatic logic [3:0] onehot(input int g);
        logic [3:0] one;
        one = 4'b0001;
        return (g < 0) ? 4'b0000 : (one << g);
    endfunction

    task automatic model_reset();
        m_valid = 1'b0;
        m_data  = 8'h00;
        m_chan  = 2'd0;
        m_rr    = 0;
    endtask

    // Called at a falling edge; returns in_ready before the edge and outputs after it.
    task automatic apply(input logic c, input logic m, input logic [1:0] s,
                         input logic [31:0] d, input logic [3:0] v, input logic r,
                         output logic [3:0] rdy, output logic ov,
                         output logic [7:0] od, output logic [1:0] oc, output int g);
        logic [31:0] dd;
        bus.cs = c; bus.mode = m; bus.sel = s; bus.in_data = d;
        bus.in_valid = v; bus.out_ready = r;
        #1;
        rdy = bus.in_ready;
        g = model_grant(c, m, s, v, r);
        @(posedge clk);
        dd = d;
        if (g >= 0) begin
            m_valid = 1'b1;
            m_data  = dd[g*8 +: 8];
            m_chan  = 2'(g);
            if (m) m_rr = (g + 1) % N;
        end else if (r) begin
            m_valid = 1'b0;
        end
        @(negedge clk);
        ov = bus.out_valid;
        od = bus.out_data;
        oc = bus.out_chan;
    endtask

    initial begin
        logic [3:0]  rdy;
        logic        ov;
        logic [7:0]  od;
        logic [1:0]  oc;
        int          g;
        int          rr_exp[6];
        int          pat_exp[3];
        logic [31:0] rr_data;
        logic        c, m, r;
        logic [1:0]  s;
        logic [31:0] d;
        logic [3:0]  v;

        vectors = 0;
        miscompares = 0;

        tbl[0] = '{1'b1, 1'b0, 2'd2, 32'h11A52244, 4'b0100, 1'b1, 4'b0100, 1'b1, 8'hA5, 2'd2};
        tbl[1] = '{1'b1, 1'b0, 2'd3, 32'h11223344, 4'b0111, 1'b1, 4'b0000, 1'b0, 8'hA5, 2'd2};
        tbl[2] = '{1'b1, 1'b0, 2'd1, 32'h00003C00, 4'b0010, 1'b0, 4'b0010, 1'b1, 8'h3C, 2'd1};
        tbl[3] = '{1'b1, 1'b0, 2'd1, 32'h00007700, 4'b0010, 1'b0, 4'b0000, 1'b1, 8'h3C, 2'd1};
        tbl[4] = '{1'b1, 1'b0, 2'd1, 32'h00007700, 4'b0010, 1'b0, 4'b0000, 1'b1, 8'h3C, 2'd1};
        tbl[5] = '{1'b1, 1'b0, 2'd1, 32'h00007700, 4'b0010, 1'b0, 4'b0000, 1'b1, 8'h3C, 2'd1};
        tbl[6] = '{1'b1, 1'b0, 2'd1, 32'h00007700, 4'b0010, 1'b1, 4'b0010, 1'b1, 8'h77, 2'd1};
        tbl[7] = '{1'b0, 1'b0, 2'd0, 32'hFFFFFFFF, 4'b1111, 1'b0, 4'b0000, 1'b1, 8'h77, 2'd1};
        tbl[8] = '{1'b0, 1'b0, 2'd0, 32'hFFFFFFFF, 4'b1111, 1'b1, 4'b0000, 1'b0, 8'h77, 2'd1};
        tbl[9] = '{1'b0, 1'b1, 2'd0, 32'hFFFFFFFF, 4'b1111, 1'b1, 4'b0000, 1'b0, 8'h77, 2'd1};

        // Reset with inputs that would otherwise grant
        rst_n = 1'b0;
        bus.cs = 1'b1; bus.mode = 1'b0; bus.sel = 2'd0;
        bus.in_data = 32'hDEADBEEF; bus.in_valid = 4'b1111; bus.out_ready = 1'b1;
        model_reset();
        repeat (2) @(negedge clk);
        chk("reset out_valid", 32'(bus.out_valid), 32'd0);
        chk("reset out_data",  32'(bus.out_data),  32'd0);
        chk("reset out_chan",  32'(bus.out_chan),  32'd0);
        chk("reset in_ready",  32'(bus.in_ready),  32'd0);
        bus.in_valid = 4'b0000;
        rst_n = 1'b1;

        // Directed table: explicit select, invalid sel, backpressure, cs drain
        for (int i = 0; i < 10; i++) begin
            apply(tbl[i].cs, tbl[i].mode, tbl[i].sel, tbl[i].data, tbl[i].valid, tbl[i].ready,
                  rdy, ov, od, oc, g);
            chk($sformatf("tbl%0d in_ready", i), 32'(rdy), 32'(tbl[i].x_rdy));
            chk($sformatf("tbl%0d out_valid", i), 32'(ov), 32'(tbl[i].x_ov));
            chk($sformatf("tbl%0d out_data", i), 32'(od), 32'(tbl[i].x_od));
            chk($sformatf("tbl%0d out_chan", i), 32'(oc), 32'(tbl[i].x_oc));
        end

        // Round-robin over all-valid inputs wraps 0,1,2,3,0,1
        rr_exp  = '{0, 1, 2, 3, 0, 1};
        rr_data = 32'hD3C2B1A0;
        for (int i = 0; i < 6; i++) begin
            apply(1'b1, 1'b1, 2'd0, rr_data, 4'b1111, 1'b1, rdy, ov, od, oc, g);
            chk($sformatf("rr%0d out_chan", i), 32'(oc), 32'(rr_exp[i]));
            chk($sformatf("rr%0d out_data", i), 32'(od), 32'(8'hA0 + 8'h11 * rr_exp[i]));
            chk($sformatf("rr%0d out_valid", i), 32'(ov), 32'd1);
        end
        apply(1'b1, 1'b1, 2'd0, rr_data, 4'b0001, 1'b1, rdy, ov, od, oc, g);
        chk("rr set ptr out_chan", 32'(oc), 32'd0);
        pat_exp = '{3, 0, 3};
        for (int i = 0; i < 3; i++) begin
            apply(1'b1, 1'b1, 2'd0, rr_data, 4'b1001, 1'b1, rdy, ov, od, oc, g);
            chk($sformatf("rr1001_%0d in_ready", i), 32'(rdy), 32'(onehot(pat_exp[i])));
            chk($sformatf("rr1001_%0d out_chan", i), 32'(oc), 32'(pat_exp[i]));
        end

        // Asynchronous reset while an entry is held and a grant is active
        bus.cs = 1'b1; bus.mode = 1'b1; bus.in_valid = 4'b1111; bus.out_ready = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        chk("async rst out_valid", 32'(bus.out_valid), 32'd0);
        chk("async rst out_data",  32'(bus.out_data),  32'd0);
        chk("async rst in_ready",  32'(bus.in_ready),  32'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;

        // Randomized traffic against the reference model
        for (int i = 0; i < 400; i++) begin
            c = ($urandom_range(0, 7) != 0);
            m = 1'($urandom_range(0, 1));
            s = 2'($urandom);
            d = $urandom;
            v = 4'($urandom);
            r = ($urandom_range(0, 3) != 0);
            apply(c, m, s, d, v, r, rdy, ov, od, oc, g);
            chk($sformatf("rnd%0d in_ready", i), 32'(rdy), 32'(onehot(g)));
            chk($sformatf("rnd%0d out_valid", i), 32'(ov), 32'(m_valid));
            chk($sformatf("rnd%0d out_data", i), 32'(od), 32'(m_data));
            chk($sformatf("rnd%0d out_chan", i), 32'(oc), 32'(m_chan));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
